// File: rtl/ml_pkg.sv
// Shared types and default widths for the ML datapath arithmetic blocks
// (multiplier and divider).
package ml_pkg;
  localparam int DIV_A_W = 8;
  localparam int DIV_B_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
  import ml_pkg::*;
#(
  parameter int B_W = DIV_B_W
) (
  input  logic [B_W:0]   prem_i,
  input  logic           bit_i,
  input  logic [B_W-1:0] divisor_i,
  output logic [B_W:0]   prem_o,
  output logic           qbit_o
);
  logic [B_W+1:0] shifted;
  logic [B_W:0]   trial;

  assign shifted = {prem_i, bit_i};
  // Full-width compare decides the quotient bit; the kept difference always
  // fits B_W+1 bits because the partial remainder stays below the divisor.
  assign qbit_o  = (shifted >= {2'b00, divisor_i});
  assign trial   = shifted[B_W:0] - {1'b0, divisor_i};
  assign prem_o  = qbit_o ? trial : shifted[B_W:0];
endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider with start/busy/done handshake.
// Handshake: enable is a start request taken only in IDLE or DONE; done pulses
// for one cycle as results land; busy is high exactly while CALC runs.
module divider
  import ml_pkg::*;
#(
  parameter int A_W = DIV_A_W,
  parameter int B_W = DIV_B_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] quotient,
  output logic [B_W-1:0] remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output div_state_t     dbg_state
);
  localparam int CNT_W = $clog2(A_W + 1);

  div_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0] shift_q, shift_d;
  logic [B_W-1:0] divisor_q, divisor_d;
  logic [B_W:0]   prem_q, prem_d;
  logic [A_W-1:0] quot_q, quot_d;
  logic [B_W-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [B_W:0]   step_prem;
  logic           step_qbit;

  div_step #(.B_W(B_W)) u_step (
    .prem_i    (prem_q),
    .bit_i     (shift_q[A_W-1]),
    .divisor_i (divisor_q),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    divisor_d = divisor_q;
    prem_d    = prem_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (enable) begin
          if (b != '0) begin
            shift_d   = a;
            divisor_d = b;
            prem_d    = '0;
            cnt_d     = CNT_W'(A_W);
            state_d   = CALC;
          end else begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // Quotient bits enter the dividend register from the bottom as the
        // dividend bits leave from the top.
        shift_d = {shift_q[A_W-2:0], step_qbit};
        prem_d  = step_prem;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quot_d  = {shift_q[A_W-2:0], step_qbit};
          rem_d   = step_prem[B_W-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      divisor_q <= '0;
      prem_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      divisor_q <= divisor_d;
      prem_q    <= prem_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;
endmodule
